// File: rtl/csa_cpa_resolve_186_pkg.sv
// csa_cpa_pkg: shared types and sizing helpers for the multi-cycle CSA resolver.
// Revision: 1.0
`default_nettype none

package csa_cpa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  localparam int WIDTH_DEF  = 186;
  localparam int CHUNK_DEF  = 32;
  localparam int NCHUNK_DEF = nchunk(WIDTH_DEF, CHUNK_DEF);
  localparam int PW         = NCHUNK_DEF * CHUNK_DEF;

endpackage

`default_nettype wire

// File: rtl/csa_cpa_resolve_186_if.sv
// csa_cpa_resolve_186_if: operand-in / result-out valid-ready bundle.
// Revision: 1.0
`default_nettype none

interface csa_cpa_resolve_186_if #(
  parameter int WIDTH = 186
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] s_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             ovf_out;

  modport master (
    output in_valid, c_in, s_in, out_ready,
    input  in_ready, out_valid, sum_out, ovf_out
  );

  modport slave (
    input  in_valid, c_in, s_in, out_ready,
    output in_ready, out_valid, sum_out, ovf_out
  );
endinterface

`default_nettype wire

// File: rtl/csa_cpa_resolve_186_chunk.sv
// cpa_chunk: combinational CHUNK-bit adder with carry in and carry out.
// Revision: 1.0
`default_nettype none

module cpa_chunk #(
  parameter int CHUNK = 32
) (
  input  wire logic [CHUNK-1:0] i_a,
  input  wire logic [CHUNK-1:0] i_b,
  input  wire logic             i_cin,
  output logic      [CHUNK-1:0] o_sum,
  output logic                  o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

endmodule

`default_nettype wire

// File: rtl/csa_cpa_resolve_186.sv
// csa_cpa_resolve_186: resolves a carry-save pair into a binary sum, CHUNK bits per clock.
// Revision: 1.0
`default_nettype none

module csa_cpa_resolve_186
  import csa_cpa_pkg::*;
#(
  parameter int WIDTH = 186,
  parameter int CHUNK = 32
) (
  input wire logic              clk,
  input wire logic              rst,
  csa_cpa_resolve_186_if.slave  bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int PWL    = NCHUNK * CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  state_t           r_state;
  logic [PWL-1:0]   r_c;
  logic [PWL-1:0]   r_s;
  logic [PWL-1:0]   r_res;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;

  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_cout;
  logic [PWL-1:0]   w_chunk_ext;
  logic [PWL-1:0]   w_res_next;
  logic             w_ovf;

  cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a    (r_c[CHUNK-1:0]),
    .i_b    (r_s[CHUNK-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_chunk_sum),
    .o_cout (w_cout)
  );

  // New chunk enters at the top; after NCHUNK shifts chunk 0 sits at bit 0.
  assign w_chunk_ext = PWL'(w_chunk_sum);
  assign w_res_next  = (r_res >> CHUNK) | (w_chunk_ext << (PWL - CHUNK));

  generate
    if (PWL > WIDTH) begin : g_pad
      // Padding above the carry-out position is always zero, so the OR is just bit WIDTH.
      assign w_ovf = |w_res_next[PWL-1:WIDTH];
    end else begin : g_nopad
      assign w_ovf = w_cout;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_c         <= '0;
      r_s         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_c        <= PWL'(bus.c_in);
            r_s        <= PWL'(bus.s_in);
            r_carry    <= 1'b0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_c     <= r_c >> CHUNK;
          r_s     <= r_s >> CHUNK;
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_k     <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_k         <= '0;
            r_sum       <= w_res_next[WIDTH-1:0];
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum_out   = r_sum;
  assign bus.ovf_out   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_csa_cpa_resolve_186.sv
// tb_csa_cpa_resolve_186: scoreboard bench for the default (6-chunk) and single-chunk resolvers.
// Revision: 1.0
`default_nettype none

module tb_csa_cpa_resolve_186;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_cpa_resolve_186_if #(.WIDTH(186)) ia ();
  csa_cpa_resolve_186_if #(.WIDTH(186)) ib ();

  csa_cpa_resolve_186 #(.WIDTH(186), .CHUNK(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  csa_cpa_resolve_186 #(.WIDTH(186), .CHUNK(186)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  int           checks = 0;
  int           errors = 0;
  logic [186:0] qa[$];
  logic [186:0] qb[$];
  bit           rand_rdy = 1'b0;

  function automatic void chk(input string nm, input logic [186:0] act, input logic [186:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [185:0] rnd();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[185:0];
  endfunction

  // Monitors: a result is consumed on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (!rst && ia.out_valid && ia.out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_result actual=%h required=none", {ia.ovf_out, ia.sum_out});
      end else begin
        chk("a_result", {ia.ovf_out, ia.sum_out}, qa.pop_front());
      end
    end
    if (!rst && ib.out_valid && ib.out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_result actual=%h required=none", {ib.ovf_out, ib.sum_out});
      end else begin
        chk("b_result", {ib.ovf_out, ib.sum_out}, qb.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      ia.out_ready = ($urandom_range(0, 3) != 0);
      ib.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at acceptance edge +1.
  task automatic send(input bit sel, input logic [185:0] c, input logic [185:0] s,
                      input logic [186:0] exp, input bit push);
    int n = 0;
    if (!sel) begin
      ia.c_in = c; ia.s_in = s; ia.in_valid = 1'b1;
      while (!ia.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    end else begin
      ib.c_in = c; ib.s_in = s; ib.in_valid = 1'b1;
      while (!ib.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout_%0d actual=%0d required=<200", sel, n);
    end
    @(posedge clk);
    if (push) begin
      if (!sel) qa.push_back(exp);
      else      qb.push_back(exp);
    end
    #1;
    if (!sel) ia.in_valid = 1'b0;
    else      ib.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, output int n);
    n = 0;
    while (((!sel) ? !ia.out_valid : !ib.out_valid) && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    int n;
    logic [185:0] c;
    logic [185:0] s;
    logic [185:0] ones;
    ones = '1;

    rst = 1'b1;
    ia.in_valid = 1'b0; ia.c_in = '0; ia.s_in = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.c_in = '0; ib.s_in = '0; ib.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_in_ready",  187'(ia.in_ready),  187'd1);
    chk("a_rst_out_valid", 187'(ia.out_valid), 187'd0);
    chk("a_rst_result",    {ia.ovf_out, ia.sum_out}, 187'd0);
    chk("b_rst_in_ready",  187'(ib.in_ready),  187'd1);
    rst = 1'b0;

    // Zero operands and latency
    send(1'b0, 186'd0, 186'd0, 187'd0, 1'b1);
    wait_valid(1'b0, n);
    chk("a_latency", 187'(n), 187'd6);
    send(1'b1, 186'd0, 186'd0, 187'd0, 1'b1);
    wait_valid(1'b1, n);
    chk("b_latency", 187'(n), 187'd1);

    // Full-length ripple into the carry-out
    send(1'b0, 186'd1, ones, {1'b1, 186'd0}, 1'b1);
    send(1'b1, 186'd1, ones, {1'b1, 186'd0}, 1'b1);

    // Carry across chunk 0 -> chunk 1
    send(1'b0, 186'd1, 186'hFFFF_FFFF, 187'h1_0000_0000, 1'b1);
    send(1'b1, 186'd1, 186'hFFFF_FFFF, 187'h1_0000_0000, 1'b1);

    // Backpressure: result held for 10 stalled cycles
    wait_valid(1'b0, n);
    @(posedge clk); #1;
    ia.out_ready = 1'b0;
    send(1'b0, 186'h8000_0000_8000_0000, 186'h8000_0000_8000_0000,
         187'h1_0000_0001_0000_0000, 1'b1);
    wait_valid(1'b0, n);
    for (int i = 0; i < 10; i++) begin
      chk("a_stall_result",   {ia.ovf_out, ia.sum_out}, 187'h1_0000_0001_0000_0000);
      chk("a_stall_in_ready", 187'(ia.in_ready),  187'd0);
      chk("a_stall_valid",    187'(ia.out_valid), 187'd1);
      @(posedge clk); #1;
    end
    ia.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("a_post_hs_valid", 187'(ia.out_valid), 187'd0);
    chk("a_post_hs_ready", 187'(ia.in_ready),  187'd1);

    // Reset during RUN at k=3 discards the operation
    send(1'b0, 186'd5, 186'd5, 187'd10, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("a_midrst_in_ready", 187'(ia.in_ready),  187'd1);
    chk("a_midrst_valid",    187'(ia.out_valid), 187'd0);
    chk("a_midrst_result",   {ia.ovf_out, ia.sum_out}, 187'd0);
    send(1'b0, 186'd5, 186'd7, 187'd12, 1'b1);
    wait_valid(1'b0, n);
    chk("a_after_rst_latency", 187'(n), 187'd6);
    @(posedge clk); #1;

    // Random traffic with gaps and random backpressure on both instances
    rand_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [185:0] rc;
          logic [185:0] rs;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rc = rnd() & ~186'd1;
          rs = (i % 50 == 0) ? ones : rnd();
          send(1'b0, rc, rs, {1'b0, rc} + {1'b0, rs}, 1'b1);
        end
      end
      begin
        for (int j = 0; j < 200; j++) begin
          logic [185:0] rc;
          logic [185:0] rs;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rc = rnd() & ~186'd1;
          rs = (j % 20 == 0) ? ones : rnd();
          send(1'b1, rc, rs, {1'b0, rc} + {1'b0, rs}, 1'b1);
        end
      end
    join

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    rand_rdy = 1'b0;
    chk("a_queue_drained", 187'(qa.size()), 187'd0);
    chk("b_queue_drained", 187'(qb.size()), 187'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
